decod_arb: RTL and testbench
============================

DECOD_ARB -- requirements
Module: decod_arb

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning maximum consecutive grant cycles per requester; 0 = unlimited.
REQ-002 SHALL have parameter GAP_CYCLES, default 1, range 1..7, meaning dead cycles between grants.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port req, input, 16, request per decoder line; bit i = requester i.
REQ-006 SHALL have port grant, output, 16, registered one-hot grant; zero when none.
REQ-007 SHALL have port sel, output, 4, registered binary index of the granted line.
REQ-008 SHALL have port en, output, 1, registered decoder enable; 1 exactly when grant != 0.
REQ-009 SHALL have port busy, output, 1, 1 when state != IDLE.

Function
REQ-010 SHALL implement the states IDLE, GRANT and GAP.
REQ-011 In IDLE with req != 0, the block SHALL select the first asserted req bit at or after ptr, scanning upward modulo 16.
- The block SHALL enter GRANT on the next edge.
- grant, sel and en SHALL become visible 1 cycle after req is sampled.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs 0.
REQ-013 In GRANT, hold_cnt SHALL start at 1 in the first grant cycle and increment by 1 each cycle.
- hold_cnt SHALL be 4 bits wide and saturate at 15.
REQ-014 GRANT SHALL exit to GAP when req[sel] == 0, or when MAX_HOLD != 0 and hold_cnt == MAX_HOLD.
- grant, sel and en SHALL be 0 from the next cycle.
REQ-015 If the req drop and hold expiry coincide, the block SHALL perform exactly one release and one ptr update.
REQ-016 On release, ptr SHALL become (sel+1) mod 16, so 15 wraps to 0.
REQ-017 The block SHALL stay in GAP for exactly GAP_CYCLES cycles with grant == 0 and en == 0, then go to IDLE.
- Requests SHALL be ignored during GAP (break-before-make).
- IDLE SHALL arbitrate in the same cycle it is entered.
REQ-018 With MAX_HOLD == 0, a grant SHALL persist while req[sel] stays 1.
REQ-019 grant SHALL never have more than one bit set.
- grant SHALL always equal one-hot(sel) when en == 1.
REQ-020 Changes to req bits other than req[sel] during GRANT SHALL not affect the current grant.

Reset
REQ-021 While rst_n == 0, the block SHALL force the following immediately, independent of clk:
- state = IDLE, grant = 0, sel = 0, en = 0, busy = 0, ptr = 0, hold_cnt = 0, gap counter = 0.
REQ-022 Reset asserted mid-GRANT or mid-GAP SHALL abort that operation; no partial release and no ptr update SHALL survive.
REQ-023 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge, from ptr = 0.

Structure
REQ-024 Package decod_pkg SHALL hold the following:
- N_LINES = 16 and IDX_W = 4;
- the state enum {IDLE, GRANT, GAP};
- the hold_cnt width constant.
REQ-025 The round-robin search SHALL be a combinational sub-module rr_pick.
- Inputs: req[15:0], ptr[3:0].
- Outputs: found, idx[3:0].
- No other sub-modules.

Verification
REQ-026 Basic handshake: reset, then req = 0x0001 held for 3 cycles, then dropped.
- Required: grant = 0x0001, sel = 0, en = 1 one cycle later for 3 cycles, then 0 for GAP_CYCLES.
- Required: ptr = 1 afterwards.
REQ-027 Round-robin: req = 0x8001 constant, MAX_HOLD = 2.
- Required grant sequence: 0x0001 x2, gap, 0x8000 x2, gap, 0x0001 x2 (ptr wraps 15 -> 0).
REQ-028 Hold expiry: MAX_HOLD = 8, req = 0x0010 constant.
- Required: grant lasts exactly 8 cycles, GAP 1 cycle, then regrant bit 4 (the only requester).
REQ-029 Simultaneous events: req[5] drops in the same cycle hold_cnt reaches MAX_HOLD.
- Required: a single release, ptr = 6, no duplicate GAP.
REQ-030 Reset mid-grant: rst_n pulsed low asynchronously between edges during a grant of line 9.
- Required: outputs are 0 immediately; after release, the first grant goes to the lowest requester from ptr = 0.
REQ-031 Every run SHALL include the following continuous assertions: grant one-hot-or-zero, en == |grant, and grant == one-hot(sel) when en == 1.

Source files
------------

// File: rtl/decod_pkg.sv
// Shared constants, state encoding and helpers for the decoder-line arbiter.
package decod_pkg;

    localparam int N_LINES = 16;
    localparam int IDX_W   = 4;
    localparam int HOLD_W  = 4;
    localparam int GAP_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_LINES-1:0] one;
        one = {{(N_LINES-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/decod_arb_chk.sv
// Continuous protocol checks on the arbiter outputs.
module decod_arb_chk
    import decod_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    input logic [N_LINES-1:0] grant,
    input logic [IDX_W-1:0]   sel,
    input logic               en
);

    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_en_match: assert property (@(posedge clk) disable iff (!rst_n) en == (|grant));
    a_sel_match: assert property (@(posedge clk) disable iff (!rst_n) en |-> (grant == onehot(sel)));

endmodule

// File: rtl/decod_arb_rr_pick.sv
// Combinational round-robin search: first asserted req bit at or above ptr,
// wrapping modulo N_LINES.
module rr_pick
    import decod_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    always_comb begin
        found  = 1'b0;
        idx    = {IDX_W{1'b0}};
        cand_s = {IDX_W{1'b0}};
        for (int k = N_LINES - 1; k >= 0; k--) begin
            cand_s = ptr + IDX_W'(k);
            if (req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/decod_arb.sv
// Round-robin arbiter driving a 4-to-16 decoder: one grant at a time, an
// optional hold limit per requester, and a fixed dead gap between grants.
module decod_arb
    import decod_pkg::*;
#(
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] req,
    output logic [N_LINES-1:0] grant,
    output logic [IDX_W-1:0]   sel,
    output logic               en,
    output logic               busy
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
    localparam logic              HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    state_t             state_r, state_s;
    logic [N_LINES-1:0] grant_r, grant_s;
    logic [IDX_W-1:0]   sel_r, sel_s;
    logic               en_r, en_s;
    logic               busy_r, busy_s;
    logic [IDX_W-1:0]   ptr_r, ptr_s;
    logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
    logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;

    logic               start_s;
    logic               release_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state and next-output logic; the last GAP cycle arbitrates like IDLE.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        sel_s      = sel_r;
        en_s       = en_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        start_s    = 1'b0;
        release_s  = 1'b0;

        case (state_r)
            IDLE: begin
                start_s = 1'b1;
            end
            GRANT: begin
                release_s = !req[sel_r] || (HOLD_EN && (hold_cnt_r == HOLD_LIMIT));
                if (release_s) begin
                    state_s    = GAP;
                    grant_s    = {N_LINES{1'b0}};
                    sel_s      = {IDX_W{1'b0}};
                    en_s       = 1'b0;
                    ptr_s      = sel_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    hold_cnt_s = {HOLD_W{1'b0}};
                    gap_cnt_s  = {GAP_W{1'b0}};
                end else if (hold_cnt_r != HOLD_SAT) begin
                    hold_cnt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s = {GAP_W{1'b0}};
                    start_s   = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = {N_LINES{1'b0}};
                sel_s      = {IDX_W{1'b0}};
                en_s       = 1'b0;
                hold_cnt_s = {HOLD_W{1'b0}};
                gap_cnt_s  = {GAP_W{1'b0}};
            end
        endcase

        if (start_s && pick_found_s) begin
            state_s    = GRANT;
            grant_s    = onehot(pick_idx_s);
            sel_s      = pick_idx_s;
            en_s       = 1'b1;
            hold_cnt_s = {{(HOLD_W-1){1'b0}}, 1'b1};
        end else if (start_s) begin
            state_s    = IDLE;
            grant_s    = {N_LINES{1'b0}};
            sel_s      = {IDX_W{1'b0}};
            en_s       = 1'b0;
            hold_cnt_s = {HOLD_W{1'b0}};
        end else begin
            state_s    = state_s;
        end

        busy_s = (state_s != IDLE);
    end

    // State and registered outputs; reset clears everything including ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            grant_r    <= {N_LINES{1'b0}};
            sel_r      <= {IDX_W{1'b0}};
            en_r       <= 1'b0;
            busy_r     <= 1'b0;
            ptr_r      <= {IDX_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            sel_r      <= sel_s;
            en_r       <= en_s;
            busy_r     <= busy_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
        end
    end

    assign grant = grant_r;
    assign sel   = sel_r;
    assign en    = en_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_decod_arb.sv
// Directed bench for decod_arb: three instances (hold limits 8, 2 and
// unlimited) share clock and reset; each scenario task checks its own results.
module tb_decod_arb;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_a, req_b, req_c;
    logic [15:0] grant_a, grant_b, grant_c;
    logic [3:0]  sel_a, sel_b, sel_c;
    logic        en_a, en_b, en_c;
    logic        busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;

    decod_arb #(.MAX_HOLD(8), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .grant(grant_a), .sel(sel_a), .en(en_a), .busy(busy_a));
    decod_arb #(.MAX_HOLD(2), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .grant(grant_b), .sel(sel_b), .en(en_b), .busy(busy_b));
    decod_arb #(.MAX_HOLD(0), .GAP_CYCLES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c),
        .grant(grant_c), .sel(sel_c), .en(en_c), .busy(busy_c));

    decod_arb_chk chk_a (.clk(clk), .rst_n(rst_n), .grant(grant_a), .sel(sel_a), .en(en_a));
    decod_arb_chk chk_b (.clk(clk), .rst_n(rst_n), .grant(grant_b), .sel(sel_b), .en(en_b));
    decod_arb_chk chk_c (.clk(clk), .rst_n(rst_n), .grant(grant_c), .sel(sel_c), .en(en_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 16'h0000; req_b = 16'h0000; req_c = 16'h0000;
        #3;
        checks++;
        if ({grant_a, sel_a, en_a, busy_a, dut_a.ptr_r} !== 26'd0) begin
            errors++;
            $display("FAIL reset_a: got %h %h %b %b ptr=%h, want all 0", grant_a, sel_a, en_a, busy_a, dut_a.ptr_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({grant_b, sel_b, en_b, busy_b, grant_c, en_c, busy_c} !== 40'd0) begin
            errors++;
            $display("FAIL reset_idle: b=%h/%h/%b/%b c=%h/%b/%b, want all 0", grant_b, sel_b, en_b, busy_b, grant_c, en_c, busy_c);
        end
    endtask

    // req = 0x0001 sampled on three edges, then dropped.
    task automatic test_basic();
        req_a = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({grant_a, sel_a, en_a, busy_a} !== {16'h0001, 4'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL basic_grant[%0d]: got %h/%h/%b/%b, want 0001/0/1/1", i, grant_a, sel_a, en_a, busy_a);
            end
        end
        req_a = 16'h0000;
        step();
        checks++;
        if ({grant_a, en_a, busy_a, dut_a.ptr_r} !== {16'h0000, 1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL basic_gap: got %h/%b/%b ptr=%h, want 0000/0/1 ptr=1", grant_a, en_a, busy_a, dut_a.ptr_r);
        end
        step();
        checks++;
        if ({grant_a, en_a, busy_a, dut_a.ptr_r} !== {16'h0000, 1'b0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL basic_idle: got %h/%b/%b ptr=%h, want 0000/0/0 ptr=1", grant_a, en_a, busy_a, dut_a.ptr_r);
        end
    endtask

    // MAX_HOLD = 2 with lines 0 and 15 requesting: alternate with wrap of ptr.
    task automatic test_round_robin();
        logic [15:0] exp_g [8];
        logic [3:0]  exp_s [8];
        exp_g = '{16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h8000, 16'h0000, 16'h0001, 16'h0001};
        exp_s = '{4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0};
        req_b = 16'h8001;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({grant_b, sel_b, en_b, busy_b} !== {exp_g[i], exp_s[i], (exp_g[i] != 16'h0000), 1'b1}) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got %h/%h/%b/%b, want %h/%h", i, grant_b, sel_b, en_b, busy_b, exp_g[i], exp_s[i]);
            end
        end
        req_b = 16'h0000;
        step();
        step();
        checks++;
        if ({busy_b, dut_b.ptr_r} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL rr_end: got busy=%b ptr=%h, want busy=0 ptr=1", busy_b, dut_b.ptr_r);
        end
    endtask

    // MAX_HOLD = 8, sole requester line 4: 8 grant cycles, 1 gap, regrant.
    task automatic test_hold_expiry();
        req_a = 16'h0010;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({grant_a, sel_a, en_a} !== {16'h0010, 4'd4, 1'b1}) begin
                errors++;
                $display("FAIL hold_grant[%0d]: got %h/%h/%b, want 0010/4/1", i, grant_a, sel_a, en_a);
            end
        end
        step();
        checks++;
        if ({grant_a, en_a, busy_a, dut_a.ptr_r} !== {16'h0000, 1'b0, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL hold_gap: got %h/%b/%b ptr=%h, want 0000/0/1 ptr=5", grant_a, en_a, busy_a, dut_a.ptr_r);
        end
        step();
        checks++;
        if ({grant_a, sel_a, en_a, dut_a.hold_cnt_r} !== {16'h0010, 4'd4, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL hold_regrant: got %h/%h/%b hold=%h, want 0010/4/1 hold=1", grant_a, sel_a, en_a, dut_a.hold_cnt_r);
        end
        req_a = 16'h0000;
        step();
        step();
    endtask

    // req[5] drops on the same edge the hold limit is reached.
    task automatic test_simultaneous();
        req_a = 16'h0020;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        checks++;
        if ({grant_a, sel_a, dut_a.hold_cnt_r} !== {16'h0020, 4'd5, 4'd8}) begin
            errors++;
            $display("FAIL simul_pre: got %h/%h hold=%h, want 0020/5 hold=8", grant_a, sel_a, dut_a.hold_cnt_r);
        end
        req_a = 16'h0000;
        step();
        checks++;
        if ({grant_a, busy_a, dut_a.ptr_r} !== {16'h0000, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL simul_release: got %h/%b ptr=%h, want 0000/1 ptr=6", grant_a, busy_a, dut_a.ptr_r);
        end
        step();
        checks++;
        if ({grant_a, busy_a, dut_a.ptr_r} !== {16'h0000, 1'b0, 4'd6}) begin
            errors++;
            $display("FAIL simul_single_gap: got %h/%b ptr=%h, want 0000/0 ptr=6", grant_a, busy_a, dut_a.ptr_r);
        end
    endtask

    // MAX_HOLD = 0: grant persists, other req bits ignored, hold saturates.
    task automatic test_unlimited();
        req_c = 16'h0004;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) req_c = 16'hFF0C;
            else req_c = req_c;
            step();
            checks++;
            if ({grant_c, sel_c, en_c} !== {16'h0004, 4'd2, 1'b1}) begin
                errors++;
                $display("FAIL unlim_grant[%0d]: got %h/%h/%b, want 0004/2/1", i, grant_c, sel_c, en_c);
            end
        end
        checks++;
        if (dut_c.hold_cnt_r !== 4'd15) begin
            errors++;
            $display("FAIL unlim_sat: hold=%h, want f", dut_c.hold_cnt_r);
        end
        req_c = 16'h0008;
        step();
        step();
        checks++;
        if ({grant_c, sel_c, en_c} !== {16'h0008, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL unlim_next: got %h/%h/%b, want 0008/3/1", grant_c, sel_c, en_c);
        end
        req_c = 16'h0000;
    endtask

    // Asynchronous reset during a grant of line 9, then restart from ptr 0.
    task automatic test_reset_mid_grant();
        req_b = 16'h0000;
        req_a = 16'h0201;
        step();
        step();
        checks++;
        if ({grant_a, sel_a} !== {16'h0200, 4'd9}) begin
            errors++;
            $display("FAIL rst_pre: got %h/%h, want 0200/9", grant_a, sel_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant_a, sel_a, en_a, busy_a, dut_a.ptr_r, dut_a.hold_cnt_r} !== 30'd0) begin
            errors++;
            $display("FAIL rst_async: got %h/%h/%b/%b ptr=%h hold=%h, want all 0", grant_a, sel_a, en_a, busy_a, dut_a.ptr_r, dut_a.hold_cnt_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({grant_a, sel_a, en_a, busy_a} !== {16'h0001, 4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rst_restart: got %h/%h/%b/%b, want 0001/0/1/1", grant_a, sel_a, en_a, busy_a);
        end
        req_a = 16'h0000;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_hold_expiry();
        test_simultaneous();
        test_unlimited();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
